// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the four traffic-light lamp channels. It enforces the
// lamp-step order, minimum dwell times, a non-red time limit and
// highway/farm exclusion. The first violation is latched with a code and a
// channel, and a flashing-red override is driven while the fault is held.
//
// state   | meaning
// S_ARM   | not armed; the next cycle samples the lamps as the reference
// S_RUN   | armed; all checks active, counters track the lamps
// S_FAULT | fault latched; counters frozen, flash_red toggling
module traffic_conflict_monitor #(
   parameter int AMBER_CYCLES = 2,
   parameter int MIN_GREEN    = 10,
   parameter int MAX_NONRED   = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       clr,
   input  logic [1:0] highwaySignal1,
   input  logic [1:0] highwaySignal2,
   input  logic [1:0] farmSignal1,
   input  logic [1:0] farmSignal2,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_chan,
   output logic       flash_red
);

   typedef enum logic [1:0] {
      S_ARM   = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   localparam logic [1:0] RED = 2'd2;

   state_t     state;
   state_t     state_n;
   logic [1:0] lamp   [4];
   logic [1:0] prev   [4];
   logic [6:0] dwell  [4];
   logic [6:0] nonred [4];
   logic [2:0] code_d;
   logic [1:0] chan_d;
   logic       hit;
   logic       conflict;

   assign lamp[0] = highwaySignal1;
   assign lamp[1] = highwaySignal2;
   assign lamp[2] = farmSignal1;
   assign lamp[3] = farmSignal2;

   assign conflict = ((lamp[0] != RED) || (lamp[1] != RED)) &&
                     ((lamp[2] != RED) || (lamp[3] != RED));

   // Evaluate every rule; later loops overwrite earlier ones so the lowest
   // code wins, and descending channel order makes the lowest channel win.
   always_comb begin
      code_d = 3'd0;
      chan_d = 2'd0;
      if (state == S_RUN) begin
         for (int i = 3; i >= 0; i--) begin
            if (go && (lamp[i] != RED) && (nonred[i] >= 7'(MAX_NONRED))) begin
               code_d = 3'd5;
               chan_d = 2'(i);
            end
         end
         for (int i = 3; i >= 0; i--) begin
            if ((lamp[i] != prev[i]) && (lamp[i] == 2'(prev[i] + 2'd1)) &&
                (prev[i] == 2'd0) && (dwell[i] < 7'(MIN_GREEN))) begin
               code_d = 3'd4;
               chan_d = 2'(i);
            end
         end
         for (int i = 3; i >= 0; i--) begin
            if ((lamp[i] != prev[i]) && (lamp[i] == 2'(prev[i] + 2'd1)) &&
                prev[i][0] && (dwell[i] < 7'(AMBER_CYCLES))) begin
               code_d = 3'd3;
               chan_d = 2'(i);
            end
         end
         // A change without a tick is treated as an illegal step.
         for (int i = 3; i >= 0; i--) begin
            if ((lamp[i] != prev[i]) &&
                ((lamp[i] != 2'(prev[i] + 2'd1)) || !go)) begin
               code_d = 3'd2;
               chan_d = 2'(i);
            end
         end
      end
      if ((state != S_FAULT) && conflict) begin
         code_d = 3'd1;
         chan_d = (lamp[2] != RED) ? 2'd2 : 2'd3;
      end
      hit = (code_d != 3'd0);
   end

   // Next-state logic for arming, running and the fault latch.
   always_comb begin
      state_n = state;
      if (clr) begin
         state_n = S_ARM;
      end else begin
         case (state)
            S_ARM, S_RUN: state_n = hit ? S_FAULT : S_RUN;
            S_FAULT:      state_n = S_FAULT;
            default:      state_n = S_ARM;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_ARM;
      else     state <= state_n;
   end

   // Fault outputs, flash override and per-channel counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault      <= 1'b0;
         fault_code <= 3'd0;
         fault_chan <= 2'd0;
         flash_red  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            prev[i]   <= 2'd0;
            dwell[i]  <= 7'd0;
            nonred[i] <= 7'd0;
         end
      end else begin
         fault     <= (state_n == S_FAULT);
         flash_red <= ((state == S_FAULT) && !clr) ? ~flash_red : 1'b0;
         if (clr) begin
            fault_code <= 3'd0;
            fault_chan <= 2'd0;
         end else if ((state != S_FAULT) && hit) begin
            fault_code <= code_d;
            fault_chan <= chan_d;
         end
         for (int i = 0; i < 4; i++) begin
            if (!clr && (state == S_ARM)) begin
               prev[i]   <= lamp[i];
               dwell[i]  <= 7'd1;
               nonred[i] <= (lamp[i] != RED) ? 7'd1 : 7'd0;
            end else if (!clr && (state == S_RUN) && !hit && go) begin
               if (lamp[i] != prev[i]) begin
                  prev[i]  <= lamp[i];
                  dwell[i] <= 7'd1;
               end else if (dwell[i] != 7'd127) begin
                  dwell[i] <= dwell[i] + 7'd1;
               end
               if (lamp[i] == RED)           nonred[i] <= 7'd0;
               else if (nonred[i] != 7'd127) nonred[i] <= nonred[i] + 7'd1;
            end
         end
      end
   end

endmodule
